// File: rtl/stream_in_buffer.sv
// stream_in_buffer
//   Pad-side ingress buffer feeding the core inStream interface.
//   Accepted pad beats land in a one-entry stage register, are written into a
//   first-word-fall-through FIFO on the following edge, and are presented on
//   the m_* side straight from FIFO storage. Fixed latency, no beat is ever
//   created, dropped or reordered.
//
// Parameters
//   DW    - stream data width
//   DEPTH - FIFO entries (power of two, >= 4)
//
// Ports
//   wb_clk_i      - single clock, rising edge
//   wb_rst_i      - synchronous active-high reset
//   en_i          - ingress enable (gates pad_ready_o from the next edge)
//   pad_valid_i   - pad-side beat valid
//   pad_data_i    - pad-side beat data
//   pad_last_i    - pad-side end of packet
//   pad_ready_o   - registered pad-side ready
//   m_valid_o     - core-side valid (FIFO not empty)
//   m_data_o      - core-side data (FIFO head)
//   m_last_o      - core-side last (FIFO head)
//   m_ready_i     - core-side ready
//   level_o       - occupancy: FIFO count plus stage entry
//   stat_clr_i    - statistics clear
//   stat_beats_o  - popped beat counter
//   stat_pkts_o   - popped packet (last) counter
//
// Build option
//   STREAM_IN_STATS_EN - when defined, enables the statistics counters;
//   otherwise both counters read constant 0 and stat_clr_i is ignored.

module stream_in_buffer #(
    parameter int DW    = 8,
    parameter int DEPTH = 16
) (
    input  logic                     wb_clk_i,
    input  logic                     wb_rst_i,
    input  logic                     en_i,
    input  logic                     pad_valid_i,
    input  logic [DW-1:0]            pad_data_i,
    input  logic                     pad_last_i,
    output logic                     pad_ready_o,
    output logic                     m_valid_o,
    output logic [DW-1:0]            m_data_o,
    output logic                     m_last_o,
    input  logic                     m_ready_i,
    output logic [$clog2(DEPTH):0]   level_o,
    input  logic                     stat_clr_i,
    output logic [15:0]              stat_beats_o,
    output logic [15:0]              stat_pkts_o
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] READY_LIMIT = (AW+1)'(DEPTH - 2);

    // Storage holds {last, data}; intentionally not reset.
    logic [DW:0]    mem_q [DEPTH];
    logic [DW:0]    head;

    logic           s_vld_q,  s_vld_d;
    logic [DW-1:0]  s_data_q, s_data_d;
    logic           s_last_q, s_last_d;
    logic           pad_ready_q, pad_ready_d;
    logic [AW-1:0]  wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]  rd_ptr_q, rd_ptr_d;
    logic [AW:0]    count_q,  count_d;
    logic [AW:0]    occ_next;

    logic           accept;
    logic           push;
    logic           pop;

    always_comb begin
        accept   = pad_valid_i && pad_ready_q;
        push     = s_vld_q;
        pop      = (count_q != '0) && m_ready_i;

        s_vld_d  = accept;
        s_data_d = s_data_q;
        s_last_d = s_last_q;
        if (accept) begin
            s_data_d = pad_data_i;
            s_last_d = pad_last_i;
        end

        wr_ptr_d = wr_ptr_q + AW'(push);
        rd_ptr_d = rd_ptr_q + AW'(pop);
        count_d  = count_q + (AW+1)'(push) - (AW+1)'(pop);

        // Ready looks at next-cycle occupancy including the stage entry, so
        // one more acceptance can still be absorbed: peak occupancy DEPTH-1.
        occ_next    = count_d + (AW+1)'(s_vld_d);
        pad_ready_d = en_i && (occ_next <= READY_LIMIT);
    end

    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            s_vld_q     <= 1'b0;
            s_data_q    <= '0;
            s_last_q    <= 1'b0;
            pad_ready_q <= 1'b0;
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            count_q     <= '0;
        end else begin
            s_vld_q     <= s_vld_d;
            s_data_q    <= s_data_d;
            s_last_q    <= s_last_d;
            pad_ready_q <= pad_ready_d;
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            count_q     <= count_d;
        end
    end

    always_ff @(posedge wb_clk_i) begin
        if (push) begin
            mem_q[wr_ptr_q] <= {s_last_q, s_data_q};
        end
    end

    assign head        = mem_q[rd_ptr_q];
    assign m_data_o    = head[DW-1:0];
    assign m_last_o    = head[DW];
    assign m_valid_o   = (count_q != '0);
    assign pad_ready_o = pad_ready_q;
    assign level_o     = count_q + (AW+1)'(s_vld_q);

`ifdef STREAM_IN_STATS_EN
    logic [15:0] beats_q, beats_d;
    logic [15:0] pkts_q,  pkts_d;

    always_comb begin
        beats_d = beats_q;
        pkts_d  = pkts_q;
        if (stat_clr_i) begin
            beats_d = '0;
            pkts_d  = '0;
        end else if (pop) begin
            beats_d = beats_q + 16'd1;
            if (m_last_o) begin
                pkts_d = pkts_q + 16'd1;
            end
        end
    end

    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            beats_q <= '0;
            pkts_q  <= '0;
        end else begin
            beats_q <= beats_d;
            pkts_q  <= pkts_d;
        end
    end

    assign stat_beats_o = beats_q;
    assign stat_pkts_o  = pkts_q;
`else
    logic unused_stat_clr;

    assign unused_stat_clr = stat_clr_i;
    assign stat_beats_o    = '0;
    assign stat_pkts_o     = '0;
`endif

endmodule

// File: tb/tb_stream_in_buffer.sv
// tb_stream_in_buffer
//   Directed bench for stream_in_buffer (DW=8, DEPTH=16). Inputs are driven
//   and outputs sampled 1 time unit after each rising clock edge.

module tb_stream_in_buffer;

    logic        clk;
    logic        rst;
    logic        en;
    logic        pad_valid;
    logic [7:0]  pad_data;
    logic        pad_last;
    logic        pad_ready;
    logic        m_valid;
    logic [7:0]  m_data;
    logic        m_last;
    logic        m_ready;
    logic [4:0]  level;
    logic        stat_clr;
    logic [15:0] stat_beats;
    logic [15:0] stat_pkts;

    int errors = 0;
    int checks = 0;

`ifdef STREAM_IN_STATS_EN
    localparam int EXP_BEATS = 10;
    localparam int EXP_PKTS  = 3;
`else
    localparam int EXP_BEATS = 0;
    localparam int EXP_PKTS  = 0;
`endif

    stream_in_buffer #(
        .DW    (8),
        .DEPTH (16)
    ) dut (
        .wb_clk_i     (clk),
        .wb_rst_i     (rst),
        .en_i         (en),
        .pad_valid_i  (pad_valid),
        .pad_data_i   (pad_data),
        .pad_last_i   (pad_last),
        .pad_ready_o  (pad_ready),
        .m_valid_o    (m_valid),
        .m_data_o     (m_data),
        .m_last_o     (m_last),
        .m_ready_i    (m_ready),
        .level_o      (level),
        .stat_clr_i   (stat_clr),
        .stat_beats_o (stat_beats),
        .stat_pkts_o  (stat_pkts)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    initial begin
        int  n;
        int  exp_rd;
        int  k;
        int  cyc;
        bit  acc;
        bit  pop;
        int  pkt_last [10];

        rst       = 1'b1;
        en        = 1'b0;
        pad_valid = 1'b0;
        pad_data  = '0;
        pad_last  = 1'b0;
        m_ready   = 1'b0;
        stat_clr  = 1'b0;

        // ---- reset state
        tick();
        tick();
        chk("rst_pad_ready", pad_ready, 0);
        chk("rst_m_valid", m_valid, 0);
        chk("rst_level", level, 0);
        chk("rst_stat_beats", stat_beats, 0);
        chk("rst_stat_pkts", stat_pkts, 0);

        // ---- single beat 0xA5/last
        rst     = 1'b0;
        en      = 1'b1;
        m_ready = 1'b1;
        tick();
        chk("ready_after_rst", pad_ready, 1);
        pad_valid = 1'b1;
        pad_data  = 8'hA5;
        pad_last  = 1'b1;
        tick();
        pad_valid = 1'b0;
        pad_last  = 1'b0;
        chk("single_level_stage", level, 1);
        chk("single_valid_early", m_valid, 0);
        tick();
        chk("single_valid", m_valid, 1);
        chk("single_data", m_data, 8'hA5);
        chk("single_last", m_last, 1);
        tick();
        chk("single_valid_after_pop", m_valid, 0);
        chk("single_level_after_pop", level, 0);

        // ---- fill with m_ready low
        m_ready = 1'b0;
        n = 0;
        for (int i = 0; i < 30; i++) begin
            pad_valid = 1'b1;
            pad_data  = 8'(n);
            pad_last  = ((n % 8) == 7);
            acc = pad_valid && pad_ready;
            tick();
            if (acc) n++;
        end
        pad_valid = 1'b0;
        chk("fill_accepted", n, 15);
        chk("fill_pad_ready", pad_ready, 0);
        chk("fill_level", level, 15);
        chk("fill_head", m_data, 0);
        tick();
        chk("fill_level_hold", level, 15);

        // ---- drain from full, 40 beats across pointer wrap
        m_ready   = 1'b1;
        pad_valid = 1'b1;
        pad_data  = 8'(n);
        pad_last  = ((n % 8) == 7);
        chk("drain_first_data", m_data, 0);
        tick();
        exp_rd = 1;
        chk("drain_level_14", level, 14);
        chk("drain_ready_back", pad_ready, 1);
        cyc = 0;
        while (exp_rd < 40 && cyc < 200) begin
            pad_valid = (n < 40);
            pad_data  = 8'(n);
            pad_last  = ((n % 8) == 7);
            acc = pad_valid && pad_ready;
            pop = m_valid && m_ready;
            if (pop) begin
                chk("stream_data", m_data, 8'(exp_rd));
                chk("stream_last", m_last, ((exp_rd % 8) == 7));
            end
            tick();
            if (acc) n++;
            if (pop) exp_rd++;
            cyc++;
        end
        pad_valid = 1'b0;
        pad_last  = 1'b0;
        chk("stream_total_out", exp_rd, 40);
        chk("stream_total_in", n, 40);
        chk("stream_level_end", level, 0);
        chk("stream_valid_end", m_valid, 0);

        // ---- en_i dropped mid-stream
        m_ready   = 1'b0;
        pad_valid = 1'b1;
        pad_data  = 8'h50;
        tick();
        pad_data  = 8'h51;
        tick();
        en        = 1'b0;
        pad_data  = 8'h52;
        tick();
        chk("en_drop_ready", pad_ready, 0);
        pad_data  = 8'h53;
        for (int i = 0; i < 5; i++) tick();
        chk("en_drop_level", level, 3);
        chk("en_drop_ready_hold", pad_ready, 0);
        pad_valid = 1'b0;
        m_ready   = 1'b1;
        k = 0;
        for (int i = 0; i < 20; i++) begin
            pop = m_valid && m_ready;
            if (pop) chk("en_drop_data", m_data, 8'(8'h50 + k));
            tick();
            if (pop) k++;
        end
        chk("en_drop_delivered", k, 3);
        chk("en_drop_level_end", level, 0);

        // ---- reset with level 7
        en      = 1'b1;
        m_ready = 1'b0;
        tick();
        chk("pre_rst_ready", pad_ready, 1);
        pad_valid = 1'b1;
        for (int i = 0; i < 7; i++) begin
            pad_data = 8'(8'h70 + i);
            tick();
        end
        pad_valid = 1'b0;
        chk("pre_rst_level", level, 7);
        rst = 1'b1;
        tick();
        chk("mid_rst_valid", m_valid, 0);
        chk("mid_rst_level", level, 0);
        chk("mid_rst_ready", pad_ready, 0);
        rst     = 1'b0;
        m_ready = 1'b1;
        tick();
        chk("post_rst_ready", pad_ready, 1);
        for (int i = 0; i < 5; i++) begin
            chk("post_rst_no_stale", m_valid, 0);
            tick();
        end
        pad_valid = 1'b1;
        pad_data  = 8'h3C;
        pad_last  = 1'b0;
        tick();
        pad_valid = 1'b0;
        tick();
        chk("post_rst_valid", m_valid, 1);
        chk("post_rst_data", m_data, 8'h3C);
        chk("post_rst_last", m_last, 0);
        tick();
        chk("post_rst_level_end", level, 0);

        // ---- statistics: packets of 4, 1, 5 beats
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("stat_rst_beats", stat_beats, 0);
        chk("stat_rst_pkts", stat_pkts, 0);
        tick();
        for (int i = 0; i < 10; i++) pkt_last[i] = (i == 3 || i == 4 || i == 9) ? 1 : 0;
        m_ready = 1'b1;
        n = 0;
        exp_rd = 0;
        cyc = 0;
        while (exp_rd < 10 && cyc < 100) begin
            pad_valid = (n < 10);
            pad_data  = 8'(8'h90 + n);
            pad_last  = (n < 10) ? pkt_last[n][0] : 1'b0;
            acc = pad_valid && pad_ready;
            pop = m_valid && m_ready;
            if (pop) begin
                chk("pkt_data", m_data, 8'(8'h90 + exp_rd));
                chk("pkt_last", m_last, pkt_last[exp_rd]);
            end
            tick();
            if (acc) n++;
            if (pop) exp_rd++;
            cyc++;
        end
        pad_valid = 1'b0;
        pad_last  = 1'b0;
        chk("pkt_beats_out", exp_rd, 10);
        chk("stat_beats", stat_beats, EXP_BEATS);
        chk("stat_pkts", stat_pkts, EXP_PKTS);

        // clear coinciding with a pop of a last beat: clear wins
        m_ready   = 1'b0;
        pad_valid = 1'b1;
        pad_data  = 8'hEE;
        pad_last  = 1'b1;
        tick();
        pad_valid = 1'b0;
        pad_last  = 1'b0;
        tick();
        chk("clr_head_valid", m_valid, 1);
        chk("clr_hold_beats", stat_beats, EXP_BEATS);
        m_ready  = 1'b1;
        stat_clr = 1'b1;
        tick();
        stat_clr = 1'b0;
        chk("clr_beats", stat_beats, 0);
        chk("clr_pkts", stat_pkts, 0);
        chk("clr_popped", m_valid, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
